uart_tx: RTL and testbench

Serial transmitter for the APB UART. Pops bytes from the TX FIFO over a valid/ready handshake and serialises each as a frame: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits. Runs on the same divisor and line-control settings the register block exposes. Frame-done and busy status feed the interrupt/IIR logic (THRE/TEMT).

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits
// Optional break forcing of the line is compiled in with UART_TX_BREAK_EN.
module uart_tx #(
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic [1:0]            cfg_bits_i,
    input  logic                  cfg_stop_i,
    input  logic                  cfg_parity_en_i,
    input  logic                  cfg_parity_even_i,
    input  logic                  cfg_break_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_timer;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_bits;
    logic                  r_stop;
    logic                  r_par_en;
    logic                  r_par_even;
    logic                  r_parity;
    logic                  r_stop_cnt;
    logic [2:0]            r_bit_cnt;

    logic w_bit_end;
    logic w_last_data;
    logic w_accept;
    logic w_tx_ready;
    logic w_frame_done;
    logic w_tx_fsm;

    assign w_bit_end   = (r_timer == '0);
    assign w_last_data = (r_bit_cnt == (3'(r_bits) + 3'd4));
    assign w_accept    = w_tx_ready & tx_valid_i;

    always_comb begin
        w_state_next = r_state;
        w_tx_ready   = 1'b0;
        w_frame_done = 1'b0;
        w_tx_fsm     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_ready = cfg_en_i & rstn_i;
                if (w_tx_ready && tx_valid_i) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_fsm = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_fsm = r_shift[0];
                if (w_bit_end && w_last_data) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                // r_parity holds the XOR of every data bit already sent
                w_tx_fsm = r_par_even ? r_parity : ~r_parity;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_stop_cnt == r_stop)) begin
                    w_frame_done = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_timer    <= '0;
            r_shift    <= '0;
            r_bits     <= '0;
            r_stop     <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_parity   <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Snapshot configuration so mid-frame register writes cannot disturb this frame
                r_shift    <= tx_data_i;
                r_div      <= cfg_div_i;
                r_timer    <= cfg_div_i;
                r_bits     <= cfg_bits_i;
                r_stop     <= cfg_stop_i;
                r_par_en   <= cfg_parity_en_i;
                r_par_even <= cfg_parity_even_i;
                r_parity   <= 1'b0;
                r_stop_cnt <= 1'b0;
                r_bit_cnt  <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_timer <= r_div;
                    if (r_state == S_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_parity  <= r_parity ^ r_shift[0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    if (r_state == S_STOP) begin
                        r_stop_cnt <= ~r_stop_cnt;
                    end
                end else begin
                    r_timer <= r_timer - DIV_WIDTH'(1);
                end
            end
        end
    end

    assign tx_ready_o   = w_tx_ready;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_done_o = w_frame_done;

`ifdef UART_TX_BREAK_EN
    assign tx_o = w_tx_fsm & ~cfg_break_i;
`else
    logic w_unused_break;
    assign w_unused_break = cfg_break_i;
    assign tx_o = w_tx_fsm;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic        cfg_stop;
    logic        cfg_pe;
    logic        cfg_pev;
    logic        cfg_brk;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic        fdone;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo[$];
    logic cap_tx[0:127];
    logic cap_busy[0:127];
    logic cap_done[0:127];
    logic cap_pop[0:127];
    logic cap_ready[0:127];

    int          hk_cyc = -1;
    logic [15:0] hk_div;
    logic        hk_en;
    logic        hk_rstn;

    always #5 clk = ~clk;

    uart_tx #(.DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .cfg_en_i(cfg_en),
        .cfg_div_i(cfg_div),
        .cfg_bits_i(cfg_bits),
        .cfg_stop_i(cfg_stop),
        .cfg_parity_en_i(cfg_pe),
        .cfg_parity_even_i(cfg_pev),
        .cfg_break_i(cfg_brk),
        .tx_data_i(tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .tx_o(tx),
        .busy_o(busy),
        .frame_done_o(fdone)
    );

    task automatic drive_fifo();
        tx_valid = (fifo.size() > 0);
        tx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [1:0] bits, input logic stop,
                           input logic pe, input logic pev);
        cfg_div  = div;
        cfg_bits = bits;
        cfg_stop = stop;
        cfg_pe   = pe;
        cfg_pev  = pev;
    endtask

    // Each recorded cycle is sampled at the falling edge; FIFO pops take effect after the rising edge
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic       pend;
            logic [7:0] junk;
            @(negedge clk);
            cap_tx[i]    = tx;
            cap_busy[i]  = busy;
            cap_done[i]  = fdone;
            cap_ready[i] = tx_ready;
            pend         = tx_valid & tx_ready;
            cap_pop[i]   = pend;
            @(posedge clk);
            #1;
            if (pend) junk = fifo.pop_front();
            drive_fifo();
            if (i == hk_cyc) begin
                cfg_div = hk_div;
                cfg_en  = hk_en;
                rstn    = hk_rstn;
            end
            if (i == hk_cyc + 1) rstn = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cfg_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (fdone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", fdone); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", tx_ready); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b expected 1", tx_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_8n1();
        logic [15:0] e;
        int nb, nd, np;
        e = 16'b1101001010;
        set_cfg(16'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        fifo.push_back(8'hA5); drive_fifo();
        run_cycles(45);
        nb = 0; nd = 0; np = 0;
        for (int c = 0; c < 45; c++) begin
            nb += int'(cap_busy[c]); nd += int'(cap_done[c]); np += int'(cap_pop[c]);
        end
        n_checks++; if (cap_pop[0] !== 1'b1) begin n_fail++; $display("FAIL 8n1_accept got %b expected 1", cap_pop[0]); end
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (cap_tx[c] !== e[(c-1)/4]) begin
                n_fail++; $display("FAIL 8n1_tx cycle %0d got %b expected %b", c, cap_tx[c], e[(c-1)/4]);
            end
        end
        n_checks++; if (nb != 40) begin n_fail++; $display("FAIL 8n1_busy_len got %0d expected 40", nb); end
        n_checks++; if (cap_done[40] !== 1'b1 || nd != 1) begin n_fail++; $display("FAIL 8n1_done at40=%b count=%0d expected 1,1", cap_done[40], nd); end
        n_checks++; if (np != 1) begin n_fail++; $display("FAIL 8n1_pops got %0d expected 1", np); end
        n_checks++; if (cap_tx[41] !== 1'b1 || cap_busy[41] !== 1'b0) begin n_fail++; $display("FAIL 8n1_idle tx=%b busy=%b expected 1,0", cap_tx[41], cap_busy[41]); end
    endtask

    task automatic test_parity_7e2();
        logic [15:0] e;
        for (int k = 0; k < 2; k++) begin
            e = (k == 0) ? 16'b11001101010 : 16'b11101101010;
            set_cfg(16'd0, 2'd2, 1'b1, 1'b1, (k == 0));
            fifo.push_back(8'h35); drive_fifo();
            run_cycles(14);
            for (int c = 1; c <= 11; c++) begin
                n_checks++;
                if (cap_tx[c] !== e[c-1]) begin
                    n_fail++; $display("FAIL par%0d_tx cycle %0d got %b expected %b", k, c, cap_tx[c], e[c-1]);
                end
            end
            n_checks++; if (cap_done[11] !== 1'b1 || cap_done[10] !== 1'b0) begin n_fail++; $display("FAIL par%0d_done at11=%b at10=%b expected 1,0", k, cap_done[11], cap_done[10]); end
            n_checks++; if (cap_busy[11] !== 1'b1 || cap_busy[12] !== 1'b0) begin n_fail++; $display("FAIL par%0d_len busy11=%b busy12=%b expected 1,0", k, cap_busy[11], cap_busy[12]); end
        end
    endtask

    task automatic test_5bit_odd();
        logic [15:0] e;
        e = 16'b10111110;
        set_cfg(16'd1, 2'd0, 1'b0, 1'b1, 1'b0);
        fifo.push_back(8'hFF); drive_fifo();
        run_cycles(20);
        for (int c = 1; c <= 16; c++) begin
            n_checks++;
            if (cap_tx[c] !== e[(c-1)/2]) begin
                n_fail++; $display("FAIL 5o1_tx cycle %0d got %b expected %b", c, cap_tx[c], e[(c-1)/2]);
            end
        end
        n_checks++; if (cap_done[16] !== 1'b1 || cap_busy[17] !== 1'b0) begin n_fail++; $display("FAIL 5o1_end done16=%b busy17=%b expected 1,0", cap_done[16], cap_busy[17]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e1, e2;
        int nd, np;
        e1 = 16'b1000000010;
        e2 = 16'b1100000000;
        set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        fifo.push_back(8'h01); fifo.push_back(8'h80); drive_fifo();
        hk_cyc = 5; hk_div = 16'd7; hk_en = 1'b1; hk_rstn = 1'b1;
        run_cycles(105);
        hk_cyc = -1;
        nd = 0; np = 0;
        for (int c = 0; c < 105; c++) begin nd += int'(cap_done[c]); np += int'(cap_pop[c]); end
        n_checks++; if (np != 2 || cap_pop[0] !== 1'b1 || cap_pop[21] !== 1'b1) begin n_fail++; $display("FAIL b2b_pops count=%0d pop0=%b pop21=%b expected 2,1,1", np, cap_pop[0], cap_pop[21]); end
        n_checks++; if (cap_tx[21] !== 1'b1 || cap_busy[21] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap tx=%b busy=%b expected 1,0", cap_tx[21], cap_busy[21]); end
        for (int c = 1; c <= 20; c++) begin
            n_checks++;
            if (cap_tx[c] !== e1[(c-1)/2]) begin
                n_fail++; $display("FAIL b2b_f1 cycle %0d got %b expected %b", c, cap_tx[c], e1[(c-1)/2]);
            end
        end
        for (int c = 22; c <= 101; c++) begin
            n_checks++;
            if (cap_tx[c] !== e2[(c-22)/8]) begin
                n_fail++; $display("FAIL b2b_f2 cycle %0d got %b expected %b", c, cap_tx[c], e2[(c-22)/8]);
            end
        end
        n_checks++; if (nd != 2 || cap_done[20] !== 1'b1 || cap_done[101] !== 1'b1) begin n_fail++; $display("FAIL b2b_done count=%0d d20=%b d101=%b expected 2,1,1", nd, cap_done[20], cap_done[101]); end
        n_checks++; if (cap_busy[102] !== 1'b0) begin n_fail++; $display("FAIL b2b_end busy got %b expected 0", cap_busy[102]); end
    endtask

    task automatic test_en_drop();
        logic [15:0] e1, e2;
        int nr;
        e1 = 16'b1010101010;
        e2 = 16'b1000011110;
        set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        fifo.push_back(8'h55); fifo.push_back(8'h0F); drive_fifo();
        hk_cyc = 3; hk_div = 16'd0; hk_en = 1'b0; hk_rstn = 1'b1;
        run_cycles(25);
        hk_cyc = -1;
        nr = 0;
        for (int c = 1; c < 25; c++) nr += int'(cap_ready[c]);
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (cap_tx[c] !== e1[c-1]) begin
                n_fail++; $display("FAIL en_drop_tx cycle %0d got %b expected %b", c, cap_tx[c], e1[c-1]);
            end
        end
        n_checks++; if (cap_done[10] !== 1'b1) begin n_fail++; $display("FAIL en_drop_done got %b expected 1", cap_done[10]); end
        n_checks++; if (nr != 0) begin n_fail++; $display("FAIL en_drop_ready asserted %0d cycles expected 0", nr); end
        n_checks++; if (fifo.size() != 1) begin n_fail++; $display("FAIL en_drop_fifo left %0d expected 1", fifo.size()); end
        cfg_en = 1'b1;
        run_cycles(12);
        n_checks++; if (cap_pop[0] !== 1'b1) begin n_fail++; $display("FAIL en_restore_pop got %b expected 1", cap_pop[0]); end
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (cap_tx[c] !== e2[c-1]) begin
                n_fail++; $display("FAIL en_restore_tx cycle %0d got %b expected %b", c, cap_tx[c], e2[c-1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int nd, nb;
        set_cfg(16'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        fifo.push_back(8'h00); drive_fifo();
        hk_cyc = 10; hk_div = 16'd3; hk_en = 1'b1; hk_rstn = 1'b0;
        run_cycles(50);
        hk_cyc = -1;
        nd = 0; nb = 0;
        for (int c = 0; c < 50; c++) nd += int'(cap_done[c]);
        for (int c = 12; c < 50; c++) nb += int'(cap_busy[c]);
        n_checks++; if (cap_tx[11] !== 1'b0 || cap_busy[11] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_before tx=%b busy=%b expected 0,1", cap_tx[11], cap_busy[11]); end
        n_checks++; if (cap_tx[12] !== 1'b1 || cap_busy[12] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after tx=%b busy=%b expected 1,0", cap_tx[12], cap_busy[12]); end
        n_checks++; if (nd != 0) begin n_fail++; $display("FAIL rst_mid_done count %0d expected 0", nd); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL rst_mid_idle busy cycles %0d expected 0", nb); end
    endtask

    task automatic test_break();
        logic [15:0] e;
`ifdef UART_TX_BREAK_EN
        e = 16'b0000000000;
`else
        e = 16'b1111111110;
`endif
        set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        cfg_brk = 1'b1;
        fifo.push_back(8'hFF); drive_fifo();
        run_cycles(13);
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (cap_tx[c] !== e[c-1]) begin
                n_fail++; $display("FAIL break_tx cycle %0d got %b expected %b", c, cap_tx[c], e[c-1]);
            end
        end
        n_checks++; if (cap_done[10] !== 1'b1 || cap_pop[0] !== 1'b1) begin n_fail++; $display("FAIL break_hs done10=%b pop0=%b expected 1,1", cap_done[10], cap_pop[0]); end
        cfg_brk = 1'b0;
        @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL break_release got %b expected 1", tx); end
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0; cfg_en = 1'b0; cfg_brk = 1'b0;
        set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        drive_fifo();
        test_reset();
        test_8n1();
        test_parity_7e2();
        test_5bit_odd();
        test_back_to_back();
        test_en_drop();
        test_reset_midframe();
        test_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
